register_bank: RTL and testbench

Architectural register file and PC/CPSR holder for the phantom pipeline. The writeback stage writes it through the same `back_dest_address` / `back_register_write_ctrl` / `back_data` bundle that the forwarding unit snoops. The decode stage reads it to produce `decode_a_data` / `decode_b_data`. It also owns the program counter (r15) and the NZCV flags produced by the ALU.

---
 rtl/phantom_pkg.sv | 28 ++
 rtl/pc_unit.sv | 59 +++++
 rtl/register_bank.sv | 105 ++++++++++
 tb/tb_register_bank.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/phantom_pkg.sv
// Shared definitions for the phantom pipeline.
//   REG_PC          register index that aliases the program counter
//   PC_STEP         sequential fetch increment in bytes
//   CPSR_*          NZCV bit positions within the 4-bit flag field
//   reg_addr_t      register address type used by the forwarding unit and stage registers
//   word_t          datapath word type
//   pc_src_t        next-PC source selection, highest priority last
package phantom_pkg;

    localparam int unsigned REG_PC  = 15;
    localparam int unsigned PC_STEP = 4;

    localparam int unsigned CPSR_N = 3;
    localparam int unsigned CPSR_Z = 2;
    localparam int unsigned CPSR_C = 1;
    localparam int unsigned CPSR_V = 0;

    typedef logic [3:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        PC_SRC_STEP,
        PC_SRC_HOLD,
        PC_SRC_BRANCH,
        PC_SRC_WB
    } pc_src_t;

endpackage

// File: rtl/pc_unit.sv
// Program counter (r15) holder.
//   clock, reset   pipeline clock, asynchronous active-high reset
//   wb_load        writeback targets r15 this cycle; wb_data is the new PC
//   branch_ctrl    load PC from branch_target
//   fetch_stall    hold PC this cycle (only when no load is pending)
//   pc             registered fetch address, bits [1:0] always zero
module pc_unit
    import phantom_pkg::*;
#(
    parameter int unsigned             DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]   RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wb_load,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  branch_ctrl,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic                  fetch_stall,
    output logic [DATA_WIDTH-1:0] pc
);

    pc_src_t               pc_src;
    logic [DATA_WIDTH-1:0] pc_next;

    function automatic logic [DATA_WIDTH-1:0] align_word(input logic [DATA_WIDTH-1:0] value);
        return {value[DATA_WIDTH-1:2], 2'b00};
    endfunction

    // Writeback beats branch beats stall; a stall never blocks a load.
    always_comb begin
        pc_src = PC_SRC_STEP;
        if (wb_load)
            pc_src = PC_SRC_WB;
        else if (branch_ctrl)
            pc_src = PC_SRC_BRANCH;
        else if (fetch_stall)
            pc_src = PC_SRC_HOLD;
    end

    always_comb begin
        pc_next = pc;
        case (pc_src)
            PC_SRC_WB:     pc_next = align_word(wb_data);
            PC_SRC_BRANCH: pc_next = align_word(branch_target);
            PC_SRC_HOLD:   pc_next = pc;
            PC_SRC_STEP:   pc_next = align_word(pc + DATA_WIDTH'(PC_STEP));
            default:       pc_next = pc;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            pc <= align_word(RESET_PC);
        else
            pc <= pc_next;
    end

endmodule

// File: rtl/register_bank.sv
// Architectural register file with PC and CPSR.
//   clock, reset                 pipeline clock, asynchronous active-high reset
//   a_address/a_data             decode read port A (combinational, with writeback bypass)
//   b_address/b_data             decode read port B (combinational, with writeback bypass)
//   back_dest_address/
//   back_register_write_ctrl/
//   back_data                    writeback bundle; destination 15 loads the PC
//   branch_ctrl/branch_target    branch load of the PC
//   fetch_stall                  hold the PC this cycle
//   cpsr_write_ctrl/cpsr_in      NZCV update from the ALU
//   pc                           registered fetch address
//   cpsr                         registered NZCV flags
module register_bank
    import phantom_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           ADDR_WIDTH     = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC       = '0,
    parameter logic [DATA_WIDTH-1:0] PC_READ_OFFSET = DATA_WIDTH'(8)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] a_address,
    input  logic [ADDR_WIDTH-1:0] b_address,
    output logic [DATA_WIDTH-1:0] a_data,
    output logic [DATA_WIDTH-1:0] b_data,
    input  logic [ADDR_WIDTH-1:0] back_dest_address,
    input  logic                  back_register_write_ctrl,
    input  logic [DATA_WIDTH-1:0] back_data,
    input  logic                  branch_ctrl,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic                  fetch_stall,
    input  logic                  cpsr_write_ctrl,
    input  logic [3:0]            cpsr_in,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [3:0]            cpsr
);

    localparam int unsigned NUM_GPR = REG_PC;
    localparam logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(REG_PC);

    logic [DATA_WIDTH-1:0] gpr [NUM_GPR];

    logic wb_to_pc;
    logic wb_to_gpr;

    assign wb_to_pc  = back_register_write_ctrl && (back_dest_address == PC_ADDR);
    assign wb_to_gpr = back_register_write_ctrl && (back_dest_address <  PC_ADDR);

    // General registers r0-r14; r15 lives in pc_unit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_GPR; i++)
                gpr[i] <= '0;
        end else if (wb_to_gpr) begin
            gpr[back_dest_address] <= back_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cpsr <= '0;
        else if (cpsr_write_ctrl)
            cpsr <= cpsr_in;
    end

    pc_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_unit (
        .clock         (clock),
        .reset         (reset),
        .wb_load       (wb_to_pc),
        .wb_data       (back_data),
        .branch_ctrl   (branch_ctrl),
        .branch_target (branch_target),
        .fetch_stall   (fetch_stall),
        .pc            (pc)
    );

    // r15 reads see the pipelined PC offset; other registers see an
    // in-flight writeback so decode never picks up a stale value.
    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] value;
        value = '0;
        if (addr == PC_ADDR)
            value = pc + PC_READ_OFFSET;
        else if (addr < PC_ADDR) begin
            if (wb_to_gpr && (back_dest_address == addr))
                value = back_data;
            else
                value = gpr[addr];
        end
        return value;
    endfunction

    always_comb begin
        a_data = read_port(a_address);
    end

    always_comb begin
        b_data = read_port(b_address);
    end

endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  a_address, b_address;
    logic [31:0] a_data, b_data;
    logic [3:0]  back_dest_address;
    logic        back_register_write_ctrl;
    logic [31:0] back_data;
    logic        branch_ctrl;
    logic [31:0] branch_target;
    logic        fetch_stall;
    logic        cpsr_write_ctrl;
    logic [3:0]  cpsr_in;
    logic [31:0] pc;
    logic [3:0]  cpsr;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: 16 architectural registers where index 15 is the PC.
    logic [31:0] model_regs [16];
    logic [3:0]  model_cpsr;

    register_bank #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (4),
        .RESET_PC       (32'h0),
        .PC_READ_OFFSET (32'd8)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .a_address                (a_address),
        .b_address                (b_address),
        .a_data                   (a_data),
        .b_data                   (b_data),
        .back_dest_address        (back_dest_address),
        .back_register_write_ctrl (back_register_write_ctrl),
        .back_data                (back_data),
        .branch_ctrl              (branch_ctrl),
        .branch_target            (branch_target),
        .fetch_stall              (fetch_stall),
        .cpsr_write_ctrl          (cpsr_write_ctrl),
        .cpsr_in                  (cpsr_in),
        .pc                       (pc),
        .cpsr                     (cpsr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_regs[i] = 32'h0;
        model_cpsr = 4'h0;
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] addr);
        if (addr == 4'd15) return model_regs[15] + 32'd8;
        if (back_register_write_ctrl && back_dest_address == addr) return back_data;
        return model_regs[addr];
    endfunction

    task automatic model_update();
        logic [31:0] next_pc;
        if (back_register_write_ctrl && back_dest_address == 4'd15)
            next_pc = back_data & ~32'h3;
        else if (branch_ctrl)
            next_pc = branch_target & ~32'h3;
        else if (fetch_stall)
            next_pc = model_regs[15];
        else
            next_pc = model_regs[15] + 32'd4;
        if (back_register_write_ctrl && back_dest_address != 4'd15)
            model_regs[back_dest_address] = back_data;
        model_regs[15] = next_pc;
        if (cpsr_write_ctrl) model_cpsr = cpsr_in;
    endtask

    task automatic set_idle();
        back_dest_address        = 4'd0;
        back_register_write_ctrl = 1'b0;
        back_data                = 32'h0;
        branch_ctrl              = 1'b0;
        branch_target            = 32'h0;
        fetch_stall              = 1'b0;
        cpsr_write_ctrl          = 1'b0;
        cpsr_in                  = 4'h0;
    endtask

    // Called between edges with inputs already driven: checks the
    // combinational read ports, then advances model and DUT one edge.
    task automatic tick();
        #1;
        check("a_data", a_data, model_read(a_address));
        check("b_data", b_data, model_read(b_address));
        check("pc", pc, model_regs[15]);
        check("cpsr", {28'h0, cpsr}, {28'h0, model_cpsr});
        @(posedge clock);
        model_update();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_address = 4'd3;
        b_address = 4'd15;
        set_idle();
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset state
        #1;
        check("rst_r3", a_data, 32'h0);
        check("rst_r15", b_data, 32'h8);
        check("rst_pc", pc, 32'h0);
        tick();

        // Write then read, with same-cycle bypass on port B
        back_register_write_ctrl = 1'b1;
        back_dest_address = 4'd5;
        back_data = 32'hDEADBEEF;
        a_address = 4'd0;
        b_address = 4'd5;
        #1 check("bypass_b", b_data, 32'hDEADBEEF);
        tick();
        set_idle();
        a_address = 4'd5;
        #1 check("read_r5", a_data, 32'hDEADBEEF);

        // Disabled write: neither stored nor bypassed
        back_dest_address = 4'd5;
        back_data = 32'h1;
        b_address = 4'd5;
        #1 check("nobypass_b", b_data, 32'hDEADBEEF);
        tick();
        #1 check("r5_kept", a_data, 32'hDEADBEEF);

        // PC sequencing from 0
        set_idle();
        branch_ctrl = 1'b1;
        branch_target = 32'h0;
        tick();
        check("pc_zero", pc, 32'h0);
        branch_ctrl = 1'b0;
        tick(); check("pc_run1", pc, 32'h4);
        tick(); check("pc_run2", pc, 32'h8);
        tick(); check("pc_run3", pc, 32'hC);
        fetch_stall = 1'b1;
        tick(); check("pc_stall1", pc, 32'hC);
        tick(); check("pc_stall2", pc, 32'hC);
        fetch_stall = 1'b0;

        // Wrap
        back_register_write_ctrl = 1'b1;
        back_dest_address = 4'd15;
        back_data = 32'hFFFFFFFC;
        tick(); check("pc_top", pc, 32'hFFFFFFFC);
        set_idle();
        tick(); check("pc_wrap", pc, 32'h0);

        // Priority: writeback r15 > branch > stall; alignment on branch
        back_register_write_ctrl = 1'b1;
        back_dest_address = 4'd15;
        back_data = 32'h100;
        branch_ctrl = 1'b1;
        branch_target = 32'h200;
        fetch_stall = 1'b1;
        tick(); check("pc_prio", pc, 32'h100);
        set_idle();
        branch_ctrl = 1'b1;
        branch_target = 32'h203;
        tick(); check("pc_branch_align", pc, 32'h200);
        set_idle();

        // CPSR update and hold
        cpsr_write_ctrl = 1'b1;
        cpsr_in = 4'b1010;
        tick(); check("cpsr_set", {28'h0, cpsr}, 32'hA);
        cpsr_in = 4'b0101;
        cpsr_write_ctrl = 1'b0;
        tick(); check("cpsr_hold", {28'h0, cpsr}, 32'hA);

        // Asynchronous reset mid-cycle after writing r3
        set_idle();
        back_register_write_ctrl = 1'b1;
        back_dest_address = 4'd3;
        back_data = 32'h55;
        tick();
        set_idle();
        a_address = 4'd3;
        b_address = 4'd15;
        #2 reset = 1'b1;
        #1;
        check("arst_pc", pc, 32'h0);
        check("arst_cpsr", {28'h0, cpsr}, 32'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("arst_r3", a_data, 32'h0);
        check("arst_r15", b_data, 32'h8);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            back_register_write_ctrl = 1'($urandom_range(0, 1));
            back_dest_address = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            back_data = $urandom;
            branch_ctrl = ($urandom_range(0, 5) == 0);
            branch_target = $urandom;
            fetch_stall = ($urandom_range(0, 3) == 0);
            cpsr_write_ctrl = 1'($urandom_range(0, 1));
            cpsr_in = 4'($urandom_range(0, 15));
            a_address = ($urandom_range(0, 2) == 0) ? back_dest_address : 4'($urandom_range(0, 15));
            b_address = ($urandom_range(0, 2) == 0) ? back_dest_address : 4'($urandom_range(0, 15));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
